// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the Breakout screen sequencer: screen codes and bus widths.
// Pure declarations, no logic.
// Screen codes double as FSM state encoding and renderer screen select.
package screen_pkg;

  localparam int SCREEN_BITS = 3;
  localparam int SCORE_BITS  = 16;

  localparam logic [SCREEN_BITS-1:0] SCR_INTRO       = 3'd0;
  localparam logic [SCREEN_BITS-1:0] SCR_READY       = 3'd1;
  localparam logic [SCREEN_BITS-1:0] SCR_IN_GAME     = 3'd2;
  localparam logic [SCREEN_BITS-1:0] SCR_PLAYER_OVER = 3'd3;
  localparam logic [SCREEN_BITS-1:0] SCR_GAME_OVER   = 3'd4;
  localparam logic [SCREEN_BITS-1:0] SCR_PAUSED      = 3'd5;

  // Largest of three frame limits, used to size the shared frame counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of pad, game-controller and renderer signals around the screen sequencer.
// master = pads/game/renderer side, slave = sequencer.
// No handshake: levels and single-cycle pulses only.
interface screen_sequencer_if;

  logic                             FRAME_DONE;
  logic                             BTN_START;
  logic                             BTN_PAUSE;
  logic                             GAME_OVER;
  logic [screen_pkg::SCORE_BITS-1:0]  SCORE;
  logic [screen_pkg::SCREEN_BITS-1:0] SCREEN_SELECT;
  logic                             CTRL_RESET;
  logic                             CTRL_PAUSE;
  logic [2:0]                       ACTIVE_PLAYER;
  logic [2:0]                       WINNER;
  logic [screen_pkg::SCORE_BITS-1:0]  HIGH_SCORE;
  logic                             NEW_HIGH_SCORE;

  modport master (
    output FRAME_DONE, BTN_START, BTN_PAUSE, GAME_OVER, SCORE,
    input  SCREEN_SELECT, CTRL_RESET, CTRL_PAUSE, ACTIVE_PLAYER,
           WINNER, HIGH_SCORE, NEW_HIGH_SCORE
  );

  modport slave (
    input  FRAME_DONE, BTN_START, BTN_PAUSE, GAME_OVER, SCORE,
    output SCREEN_SELECT, CTRL_RESET, CTRL_PAUSE, ACTIVE_PLAYER,
           WINNER, HIGH_SCORE, NEW_HIGH_SCORE
  );

endinterface

// File: rtl/screen_sequencer_button_debouncer.sv
// Synchronises and debounces one raw button, emits a one-cycle press on the rising debounced edge.
// Latency: raw edge to press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
// No backpressure; holding the button yields exactly one press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 400000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync <= 2'b00;
    else          sync <= {sync[0], btn};
  end

  // Accept the new level only after it has been stable for DEBOUNCE_CYCLES cycles;
  // any return to the current level restarts the count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge detect of the debounced level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Breakout screen/flow controller: intro, ready, play, per-player result, game over; tracks scores and high score.
// Latency: a state change appears on SCREEN_SELECT one cycle after the triggering input is sampled.
// No backpressure. Optional pause screen built when SCREEN_PAUSE_EN is defined.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int READY_FRAMES    = 120,
  parameter int HOLD_FRAMES     = 180,
  parameter int IDLE_FRAMES     = 1800
) (
  input logic               CLK,
  input logic               RESET_N,
  screen_sequencer_if.slave bus
);

  localparam int FCW = $clog2(max3(READY_FRAMES, HOLD_FRAMES, IDLE_FRAMES)) + 1;

  logic [SCREEN_BITS-1:0]                  state, state_nxt;
  logic [FCW-1:0]                          frame_cnt;
  logic [2:0]                              active_player;
  logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0]  score;
  logic [2:0]                              winner;
  logic [SCORE_BITS-1:0]                   high_score;
  logic                                    new_high;
  logic                                    ctrl_reset, ctrl_pause;

  logic start_press, pause_press;
  logic latch_score, clear_game, adv_player, do_result;
  logic ready_hit, hold_hit, idle_hit, last_player;
  logic [2:0]            best_idx;
  logic [SCORE_BITS-1:0] best_score;

  // Start level is only needed as a press source; the level output is left unused.
  logic unused_start_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .btn     (bus.BTN_START),
    .level   (unused_start_level),
    .press   (start_press)
  );

`ifdef SCREEN_PAUSE_EN
  logic unused_pause_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .btn     (bus.BTN_PAUSE),
    .level   (unused_pause_level),
    .press   (pause_press)
  );
`else
  logic unused_pause_btn;
  assign unused_pause_btn = bus.BTN_PAUSE;
  assign pause_press      = 1'b0;
`endif

  // A limit is reached on the FRAME_DONE pulse that brings the count up to it.
  assign ready_hit   = bus.FRAME_DONE && (frame_cnt == FCW'(READY_FRAMES - 1));
  assign hold_hit    = bus.FRAME_DONE && (frame_cnt == FCW'(HOLD_FRAMES - 1));
  assign idle_hit    = bus.FRAME_DONE && (frame_cnt == FCW'(IDLE_FRAMES - 1));
  assign last_player = (active_player == 3'(NUM_PLAYERS - 1));

  // Best score of the game; strict compare keeps the lowest index on ties.
  always_comb begin
    best_score = score[0];
    best_idx   = 3'd0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score[i] > best_score) begin
        best_score = score[i];
        best_idx   = 3'(i);
      end
    end
  end

  // Next-state logic plus the side-effect strobes for the datapath registers.
  always_comb begin
    state_nxt   = state;
    latch_score = 1'b0;
    clear_game  = 1'b0;
    adv_player  = 1'b0;
    do_result   = 1'b0;
    case (state)
      SCR_INTRO: begin
        if (start_press) begin
          state_nxt  = SCR_READY;
          clear_game = 1'b1;
        end
      end
      SCR_READY: begin
        if (ready_hit || start_press) state_nxt = SCR_IN_GAME;
      end
      SCR_IN_GAME: begin
        // GAME_OVER wins over any simultaneous button press.
        if (bus.GAME_OVER) begin
          state_nxt   = SCR_PLAYER_OVER;
          latch_score = 1'b1;
        end else if (pause_press) begin
          state_nxt = SCR_PAUSED;
        end
      end
`ifdef SCREEN_PAUSE_EN
      SCR_PAUSED: begin
        if (pause_press) state_nxt = SCR_IN_GAME;
      end
`endif
      SCR_PLAYER_OVER: begin
        if (hold_hit || start_press) begin
          if (last_player) begin
            state_nxt = SCR_GAME_OVER;
            do_result = 1'b1;
          end else begin
            state_nxt  = SCR_READY;
            adv_player = 1'b1;
          end
        end
      end
      SCR_GAME_OVER: begin
        if (idle_hit || start_press) state_nxt = SCR_INTRO;
      end
      default: state_nxt = SCR_INTRO;
    endcase
  end

  // State register and frame counter; the counter restarts on every state change.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= SCR_INTRO;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  frame_cnt <= '0;
      else if (bus.FRAME_DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Active player index and per-player score store.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      active_player <= 3'd0;
      score         <= '0;
    end else if (clear_game) begin
      active_player <= 3'd0;
      score         <= '0;
    end else begin
      if (adv_player) active_player <= active_player + 3'd1;
      if (latch_score) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (active_player == 3'(i)) score[i] <= bus.SCORE;
        end
      end
    end
  end

  // End-of-game result: winner, persistent high score and new-record flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      winner     <= 3'd0;
      high_score <= '0;
      new_high   <= 1'b0;
    end else if (clear_game) begin
      new_high <= 1'b0;
    end else if (do_result) begin
      winner <= best_idx;
      if (best_score > high_score) begin
        high_score <= best_score;
        new_high   <= 1'b1;
      end else begin
        new_high <= 1'b0;
      end
    end
  end

  // Controller strobes registered from the next state so they align with SCREEN_SELECT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_reset <= 1'b1;
      ctrl_pause <= 1'b0;
    end else begin
      ctrl_reset <= (state_nxt == SCR_INTRO) || (state_nxt == SCR_READY) ||
                    (state_nxt == SCR_GAME_OVER);
      ctrl_pause <= (state_nxt == SCR_PLAYER_OVER) || (state_nxt == SCR_PAUSED);
    end
  end

  assign bus.SCREEN_SELECT  = state;
  assign bus.CTRL_RESET     = ctrl_reset;
  assign bus.CTRL_PAUSE     = ctrl_pause;
  assign bus.ACTIVE_PLAYER  = active_player;
  assign bus.WINNER         = winner;
  assign bus.HIGH_SCORE     = high_score;
  assign bus.NEW_HIGH_SCORE = new_high;

endmodule
